key_entry: RTL and testbench
============================

Name: key_entry

Overview:
- Operator input block: the input-side counterpart of the seven-segment display driver.
- Debounces five push-buttons and lets the operator edit an 8-digit value one nibble at a time.
- On Enter, delivers the value to the CPU as a 32-bit word with a one-cycle valid pulse.
- Exports the live edit buffer and cursor so the display path can show the value being typed.

Parameters:
- DEBOUNCE_CYCLES, 100_000: clk cycles between debounce samples (1 kHz at 100 MHz).
- STABLE_SAMPLES, 4: consecutive identical samples needed before a button's debounced level changes.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- btn_up  input  1  raw button, increment digit at cursor
- btn_down  input  1  raw button, decrement digit at cursor
- btn_left  input  1  raw button, move cursor toward more-significant digit
- btn_right  input  1  raw button, move cursor toward less-significant digit
- btn_enter  input  1  raw button, commit value
- entry_enable  input  1  CPU input request (syscall read), level, high while CPU waits
- entry_data  output  32  committed value
- entry_valid  output  1  one-cycle pulse, entry_data valid
- edit_data  output  32  live edit buffer, digit k at bits [4k+3:4k]
- cursor  output  3  index of the digit being edited (0 = least significant)
- editing  output  1  high while in EDIT (or CONVERT)

Behaviour:
- Reset (rst sampled high at a clk edge):
  - Outputs: entry_data=0, entry_valid=0, edit_data=0, cursor=0, editing=0.
  - Internal state: FSM=IDLE, debounce counters=0, debounced levels=0, sample tick counter=0.
  - Reset mid-edit discards the buffer; no entry_valid is produced.
- Debounce, per button:
  - A sample tick fires once every DEBOUNCE_CYCLES clk cycles.
  - A button's debounced level changes only after STABLE_SAMPLES consecutive ticks sample the opposite raw value.
  - A 0->1 transition of the debounced level produces a one-clk press pulse.
  - Holding a button gives exactly one press; no auto-repeat.
- FSM states: IDLE, EDIT, CONVERT (only when the macro is defined), DONE.
- IDLE:
  - Ignores all press pulses.
  - On the rising edge of entry_enable: go to EDIT, clear edit_data to 0, set cursor=0.
- EDIT, press handling:
  - Only one press is honoured per cycle. Priority: enter > up > down > left > right; the others are dropped.
  - up: selected digit +1, wrapping F->0.
  - down: selected digit -1, wrapping 0->F.
  - left: cursor+1, wrapping 7->0.
  - right: cursor-1, wrapping 0->7.
  - Digit arithmetic is 4-bit modulo and never carries into the adjacent digit.
- EDIT, exits:
  - Enter press seen at edge N: go to DONE. entry_data<=edit_data and entry_valid=1 are registered at edge N, so both are visible during cycle N+1.
  - entry_enable low: abort to IDLE. No valid pulse; edit_data is retained for display.
- DONE:
  - Lasts one cycle: entry_valid deasserts and the FSM returns to IDLE.
  - If entry_enable is still high, a new entry requires entry_enable to fall and rise again.
- Output timing: entry_valid is never high for more than one consecutive cycle. editing is a registered copy of the state decode.

Optional Feature:
- Macro: KEY_ENTRY_DEC_ENTRY_EN.
- Defined (decimal entry):
  - Digits wrap 9<->0 instead of F<->0.
  - Enter moves the FSM to CONVERT. CONVERT runs 8 cycles, digit 7 down to digit 0, with acc<=acc*10+digit (32-bit; acc*10 formed as (acc<<3)+(acc<<1)).
  - entry_data=acc and entry_valid are registered at the end of the 8th CONVERT cycle, so entry_valid is high in cycle N+9.
  - entry_enable falling during CONVERT aborts to IDLE with no valid pulse.
- Undefined: hex entry as described in Behaviour; the CONVERT state and the multiply logic are absent.

Decomposition:
- Shared package:
  - FSM state encoding constants: IDLE=2'd0, EDIT=2'd1, CONVERT=2'd2, DONE=2'd3.
  - Digit count 8.
  - Button index constants: ENTER, UP, DOWN, LEFT, RIGHT.
- Sub-module btn_debounce: one instance per button, parameterised by STABLE_SAMPLES, fed by a shared sample-tick enable generated in key_entry. Outputs the debounced level and the press pulse.

Test Plan (DEBOUNCE_CYCLES=4, STABLE_SAMPLES=2):
- Basic entry: rst, raise entry_enable, press up 3 times, left once, up once -> edit_data=0x00000013, cursor=1. Then press enter -> entry_data=0x00000013 and entry_valid high exactly one cycle.
- Debounce: btn_up toggled every 3 clk for 40 clk, then held high 20 clk -> exactly one increment. A high glitch shorter than 2 sample ticks -> no increment.
- Wrap-around:
  - down at digit=0 -> F.
  - right at cursor=0 -> cursor=7.
  - up at digit F -> 0, with the neighbouring digit unchanged.
- Simultaneous presses: up and enter debounced in the same cycle -> commit of the old value, no increment. left+right together -> cursor moves left only.
- Abort and reset:
  - entry_enable dropped mid-edit -> no entry_valid, state IDLE.
  - rst asserted mid-edit -> all outputs 0 on the next cycle.
  - Button presses in IDLE -> edit_data unchanged.
- KEY_ENTRY_DEC_ENTRY_EN: enter digits 1,2,3,4 (digit 3 = 1 ... digit 0 = 4) -> entry_data=32'd1234 (0x4D2), entry_valid 9 cycles after enter. up on digit 9 -> 0.

Source files
------------

// File: rtl/key_entry_pkg.sv
// Shared definitions for the key_entry operator input block: FSM encoding,
// digit count and button indices (index order doubles as press priority).
package key_entry_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EDIT    = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int NUM_DIGITS = 8;
    localparam int NUM_BTNS   = 5;

    localparam int ENTER = 0;
    localparam int UP    = 1;
    localparam int DOWN  = 2;
    localparam int LEFT  = 3;
    localparam int RIGHT = 4;

endpackage

// File: rtl/key_entry_btn_debounce.sv
// Per-button debouncer: synchronises the raw input, changes the debounced level
// after STABLE_SAMPLES consecutive opposite samples, and emits a press pulse on rise.
module btn_debounce
    import key_entry_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES + 1) : 1;

    logic [1:0]    sync_p0;
    logic [CW-1:0] cnt;
    logic          level_p1;
    logic          raw_s;

    assign raw_s = sync_p0[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0  <= '0;
            cnt      <= '0;
            level    <= 1'b0;
            level_p1 <= 1'b0;
        end else begin
            sync_p0  <= {sync_p0[0], raw};
            level_p1 <= level;
            if (tick) begin
                // Any sample that agrees with the current level restarts the run.
                if (raw_s != level) begin
                    if (cnt == CW'(STABLE_SAMPLES - 1)) begin
                        level <= raw_s;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

    assign press = level & ~level_p1;

endmodule

// File: rtl/key_entry.sv
// Operator key entry: debounced buttons edit an 8-digit buffer, Enter commits it.
// Optional decimal entry with binary conversion when KEY_ENTRY_DEC_ENTRY_EN is defined.
module key_entry
    import key_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100_000,
    parameter int STABLE_SAMPLES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_enter,
    input  logic        entry_enable,
    output logic [31:0] entry_data,
    output logic        entry_valid,
    output logic [31:0] edit_data,
    output logic [2:0]  cursor,
    output logic        editing
);

    localparam int TW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
`ifdef KEY_ENTRY_DEC_ENTRY_EN
    localparam logic [3:0] DIGIT_MAX = 4'd9;
`else
    localparam logic [3:0] DIGIT_MAX = 4'hF;
`endif

    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d == DIGIT_MAX) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] digit_dec(input logic [3:0] d);
        return (d == 4'd0) ? DIGIT_MAX : d - 4'd1;
    endfunction

    logic [TW-1:0]       tick_cnt;
    logic                tick;
    logic [NUM_BTNS-1:0] raw_btn;
    logic [NUM_BTNS-1:0] press_btn;
    // Debounced levels are not needed here; only the press edges drive the editor.
    logic [NUM_BTNS-1:0] btn_level_unused;

    state_t state, state_nxt;
    logic   enable_p0, enable_rise;
    logic   do_enter, do_up, do_down, do_left, do_right;
    logic   editing_nxt, valid_nxt;
    logic [3:0] cur_digit;

    assign tick = (tick_cnt == TW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) tick_cnt <= '0;
        else             tick_cnt <= tick_cnt + 1'b1;
    end

    assign raw_btn = {btn_right, btn_left, btn_down, btn_up, btn_enter};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
        btn_debounce #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .tick (tick),
            .raw  (raw_btn[i]),
            .level(btn_level_unused[i]),
            .press(press_btn[i])
        );
    end

    // Lower button index wins; everything else pressed in the same cycle is dropped.
    assign do_enter = press_btn[ENTER];
    assign do_up    = press_btn[UP]    & ~press_btn[ENTER];
    assign do_down  = press_btn[DOWN]  & ~|press_btn[UP:ENTER];
    assign do_left  = press_btn[LEFT]  & ~|press_btn[DOWN:ENTER];
    assign do_right = press_btn[RIGHT] & ~|press_btn[LEFT:ENTER];

    assign enable_rise = entry_enable & ~enable_p0;
    assign cur_digit   = edit_data[{cursor, 2'b00} +: 4];

`ifdef KEY_ENTRY_DEC_ENTRY_EN
    logic [31:0] acc, acc_nxt;
    logic [2:0]  conv_cnt;
    logic [3:0]  conv_digit;

    // Most-significant digit first: index 7 - conv_cnt.
    assign conv_digit = edit_data[{~conv_cnt, 2'b00} +: 4];
    assign acc_nxt    = (acc << 3) + (acc << 1) + {28'd0, conv_digit};
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable_rise) state_nxt = EDIT;
            EDIT: begin
                if (!entry_enable) state_nxt = IDLE;
`ifdef KEY_ENTRY_DEC_ENTRY_EN
                else if (do_enter) state_nxt = CONVERT;
`else
                else if (do_enter) state_nxt = DONE;
`endif
            end
`ifdef KEY_ENTRY_DEC_ENTRY_EN
            CONVERT: begin
                if (!entry_enable)          state_nxt = IDLE;
                else if (conv_cnt == 3'd7)  state_nxt = DONE;
            end
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        editing_nxt = (state_nxt == EDIT) || (state_nxt == CONVERT);
        valid_nxt   = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            editing     <= 1'b0;
            entry_valid <= 1'b0;
        end else begin
            editing     <= editing_nxt;
            entry_valid <= valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_p0  <= 1'b0;
            edit_data  <= '0;
            cursor     <= '0;
            entry_data <= '0;
`ifdef KEY_ENTRY_DEC_ENTRY_EN
            acc        <= '0;
            conv_cnt   <= '0;
`endif
        end else begin
            enable_p0 <= entry_enable;
            case (state)
                IDLE: begin
                    if (enable_rise) begin
                        edit_data <= '0;
                        cursor    <= '0;
                    end
                end
                EDIT: begin
                    if (entry_enable) begin
                        if (do_enter) begin
`ifdef KEY_ENTRY_DEC_ENTRY_EN
                            acc      <= '0;
                            conv_cnt <= '0;
`else
                            entry_data <= edit_data;
`endif
                        end else if (do_up) begin
                            edit_data[{cursor, 2'b00} +: 4] <= digit_inc(cur_digit);
                        end else if (do_down) begin
                            edit_data[{cursor, 2'b00} +: 4] <= digit_dec(cur_digit);
                        end else if (do_left) begin
                            cursor <= cursor + 3'd1;
                        end else if (do_right) begin
                            cursor <= cursor - 3'd1;
                        end
                    end
                end
`ifdef KEY_ENTRY_DEC_ENTRY_EN
                CONVERT: begin
                    acc      <= acc_nxt;
                    conv_cnt <= conv_cnt + 3'd1;
                    if (conv_cnt == 3'd7) entry_data <= acc_nxt;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_entry.sv
// Scoreboard bench for key_entry with fast debounce (DEBOUNCE_CYCLES=4, STABLE_SAMPLES=2).
module tb_key_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  btns;
    logic        entry_enable;
    logic [31:0] entry_data;
    logic        entry_valid;
    logic [31:0] edit_data;
    logic [2:0]  cursor;
    logic        editing;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];

`ifdef KEY_ENTRY_DEC_ENTRY_EN
    localparam logic [3:0] DMAX = 4'd9;
`else
    localparam logic [3:0] DMAX = 4'hF;
`endif

    localparam int B_ENTER = 0, B_UP = 1, B_DOWN = 2, B_LEFT = 3, B_RIGHT = 4;

    always #5 clk = ~clk;

    key_entry #(
        .DEBOUNCE_CYCLES(4),
        .STABLE_SAMPLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_up      (btns[B_UP]),
        .btn_down    (btns[B_DOWN]),
        .btn_left    (btns[B_LEFT]),
        .btn_right   (btns[B_RIGHT]),
        .btn_enter   (btns[B_ENTER]),
        .entry_enable(entry_enable),
        .entry_data  (entry_data),
        .entry_valid (entry_valid),
        .edit_data   (edit_data),
        .cursor      (cursor),
        .editing     (editing)
    );

    // Value the CPU should receive for a given edit buffer.
    function automatic logic [31:0] exp_value(input logic [31:0] v);
`ifdef KEY_ENTRY_DEC_ENTRY_EN
        logic [31:0] r;
        r = 32'd0;
        for (int k = 7; k >= 0; k--) r = r * 32'd10 + {28'd0, v[4*k +: 4]};
        return r;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int idx);
        btns[idx] = 1'b1;
        wait_clk(24);
        btns[idx] = 1'b0;
        wait_clk(24);
    endtask

    task automatic press_n(input int idx, input int n);
        for (int i = 0; i < n; i++) press(idx);
    endtask

    task automatic new_entry();
        entry_enable = 1'b0;
        wait_clk(3);
        entry_enable = 1'b1;
        wait_clk(3);
    endtask

    // Monitor: every valid pulse must be single-cycle and match the oldest expectation.
    initial begin
        logic prev_valid;
        logic [31:0] e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (entry_valid === 1'b1) begin
                chk("valid_pulse_width", {31'd0, prev_valid}, 32'd0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got data 0x%08h with no entry expected", entry_data);
                end else begin
                    e = sb.pop_front();
                    chk("entry_data", entry_data, e);
                end
            end
            prev_valid = entry_valid;
        end
    end

    initial begin
        rst          = 1'b1;
        btns         = '0;
        entry_enable = 1'b0;
        wait_clk(3);
        chk("rst_entry_data",  entry_data, 32'd0);
        chk("rst_entry_valid", {31'd0, entry_valid}, 32'd0);
        chk("rst_edit_data",   edit_data, 32'd0);
        chk("rst_cursor",      {29'd0, cursor}, 32'd0);
        chk("rst_editing",     {31'd0, editing}, 32'd0);
        rst = 1'b0;
        wait_clk(3);

        // Basic entry
        new_entry();
        chk("editing_on", {31'd0, editing}, 32'd1);
        press_n(B_UP, 3);
        press(B_LEFT);
        press(B_UP);
        chk("basic_edit", edit_data, 32'h0000_0013);
        chk("basic_cursor", {29'd0, cursor}, 32'd1);
        sb.push_back(exp_value(32'h0000_0013));
        press(B_ENTER);
        chk("editing_off_after_enter", {31'd0, editing}, 32'd0);

        // Wrap-around
        new_entry();
        chk("clear_on_entry", edit_data, 32'd0);
        press(B_DOWN);
        chk("down_wrap", edit_data, {28'd0, DMAX});
        press(B_RIGHT);
        chk("right_wrap", {29'd0, cursor}, 32'd7);
        press_n(B_LEFT, 2);
        chk("left_wrap", {29'd0, cursor}, 32'd1);
        press(B_UP);
        press(B_RIGHT);
        press(B_UP);
        chk("up_wrap_no_carry", edit_data, 32'h0000_0010);

        // Debounce: bouncing then hold gives one increment; short glitch gives none
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btns[B_UP] = ~btns[B_UP];
            wait_clk(1);
        end
        btns[B_UP] = 1'b1;
        wait_clk(20);
        btns[B_UP] = 1'b0;
        wait_clk(24);
        chk("bounce_one_inc", edit_data, 32'h0000_0011);
        btns[B_UP] = 1'b1;
        wait_clk(3);
        btns[B_UP] = 1'b0;
        wait_clk(24);
        chk("glitch_no_inc", edit_data, 32'h0000_0011);

        // Simultaneous up+enter: commit old value, no increment
        sb.push_back(exp_value(32'h0000_0011));
        btns[B_UP]    = 1'b1;
        btns[B_ENTER] = 1'b1;
        wait_clk(24);
        btns = '0;
        wait_clk(24);
        chk("up_enter_no_inc", edit_data, 32'h0000_0011);

        // left+right together: left wins
        new_entry();
        chk("cursor_cleared", {29'd0, cursor}, 32'd0);
        btns[B_LEFT]  = 1'b1;
        btns[B_RIGHT] = 1'b1;
        wait_clk(24);
        btns = '0;
        wait_clk(24);
        chk("left_over_right", {29'd0, cursor}, 32'd1);

        // Abort, then presses in IDLE are ignored
        press(B_UP);
        entry_enable = 1'b0;
        wait_clk(5);
        chk("abort_editing", {31'd0, editing}, 32'd0);
        chk("abort_keeps_edit", edit_data, 32'h0000_0010);
        press(B_UP);
        press(B_ENTER);
        chk("idle_ignores", edit_data, 32'h0000_0010);

        // Four-digit entry 1,2,3,4
        new_entry();
        press_n(B_LEFT, 3);
        press(B_UP);
        press(B_RIGHT);
        press_n(B_UP, 2);
        press(B_RIGHT);
        press_n(B_UP, 3);
        press(B_RIGHT);
        press_n(B_UP, 4);
        chk("digits_1234", edit_data, 32'h0000_1234);
        sb.push_back(exp_value(32'h0000_1234));
        press(B_ENTER);

        // Reset mid-edit
        new_entry();
        press(B_UP);
        chk("pre_reset_edit", edit_data, 32'h0000_0001);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_entry_data",  entry_data, 32'd0);
        chk("midrst_entry_valid", {31'd0, entry_valid}, 32'd0);
        chk("midrst_edit_data",   edit_data, 32'd0);
        chk("midrst_cursor",      {29'd0, cursor}, 32'd0);
        chk("midrst_editing",     {31'd0, editing}, 32'd0);
        entry_enable = 1'b0;
        wait_clk(1);
        rst = 1'b0;
        wait_clk(10);

        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
